// File: rtl/fb_pkg.sv
// Framebuffer path shared constants: SDRAM command codes,
// word-address field layout and display line geometry.
package fb_pkg;
  localparam int ADDR_W     = 21;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 240;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  localparam int BANK_MSB = 20;
  localparam int BANK_LSB = 19;
  localparam int ROW_MSB  = 18;
  localparam int ROW_LSB  = 8;
  localparam int COL_MSB  = 7;
  localparam int COL_LSB  = 0;
endpackage

// File: rtl/fb_line_ram.sv
// Ping-pong line buffer: 512 x DATA_WIDTH simple dual-port RAM.
// Ports: clk/rst, write (we, wr_adr, wr_dat), registered read (rd_adr -> rd_dat).
module fb_line_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  wr_adr,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic [ADDR_BITS-1:0]  rd_adr,
  output logic [DATA_WIDTH-1:0] rd_dat
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_adr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_dat <= '0;
    else
      rd_dat <= mem[rd_adr];
  end
endmodule

// File: rtl/fb_line_fetch.sv
// Scan-out line fetcher: one SDRAM burst per display line into the back
// half of a ping-pong buffer, then swap. Ports: line request/status,
// display read port (rd_adr_i/rd_dat_o), sdram_burst command/data.
module fb_line_fetch
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 21,
  parameter int DATA_WIDTH     = 32,
  parameter int BLEN_WIDTH     = 8,
  parameter int CMD_WIDTH      = 2,
  parameter int LINE_WORDS     = fb_pkg::LINE_WORDS,
  parameter int LINE_NUM_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      line_req_i,
  input  logic [LINE_NUM_WIDTH-1:0] line_num_i,
  input  logic [ADDR_WIDTH-1:0]     frame_base_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      short_o,
  output logic                      overrun_o,
  output logic                      buf_sel_o,
  input  logic [7:0]                rd_adr_i,
  output logic [DATA_WIDTH-1:0]     rd_dat_o,
  output logic [CMD_WIDTH-1:0]      cmd_o,
  output logic [ADDR_WIDTH-1:0]     adr_o,
  output logic [BLEN_WIDTH-1:0]     len_o,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  input  logic                      valid_i
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [8:0]            count;
  logic                  full;
  logic                  we;
  logic [8:0]            wr_adr;
  logic [ADDR_WIDTH-1:0] adr_next;

  assign full     = (count == 9'(LINE_WORDS));
  assign busy_o   = (state != S_IDLE);
  assign len_o    = BLEN_WIDTH'(LINE_WORDS);
  assign adr_next = frame_base_i
                  + (ADDR_WIDTH'(line_num_i) << ROW_LSB);

  // Word 0 lands in REQ (count is 0 there); later
  // words in XFER until the line is full.
  always_comb begin
    we     = 1'b0;
    wr_adr = {~buf_sel_o, count[7:0]};
    if (valid_i)
      we = (state == S_REQ) ||
           ((state == S_XFER) && !full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      cmd_o     <= CMD_WIDTH'(CMD_NOP);
      adr_o     <= '0;
      done_o    <= 1'b0;
      short_o   <= 1'b0;
      overrun_o <= 1'b0;
      buf_sel_o <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      short_o <= 1'b0;
      if (line_req_i && (state != S_IDLE))
        overrun_o <= 1'b1;
      case (state)
        S_IDLE: begin
          if (line_req_i) begin
            adr_o <= adr_next;
            count <= '0;
            cmd_o <= CMD_WIDTH'(CMD_READ);
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (valid_i) begin
            cmd_o <= CMD_WIDTH'(CMD_NOP);
            count <= 9'd1;
            state <= S_XFER;
          end
        end
        S_XFER: begin
          if (full) begin
            state     <= S_DONE;
            done_o    <= 1'b1;
            buf_sel_o <= ~buf_sel_o;
          end else if (valid_i) begin
            count <= count + 9'd1;
          end else begin
            state   <= S_DONE;
            done_o  <= 1'b1;
            short_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fb_line_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (9)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .wr_adr (wr_adr),
    .wr_dat (dat_i),
    .rd_adr ({buf_sel_o, rd_adr_i}),
    .rd_dat (rd_dat_o)
  );
endmodule

// File: tb/tb_fb_line_fetch.sv
// Self-checking bench for fb_line_fetch: table of line fetches
// against a burst model, plus reset-abort sequence.
module tb_fb_line_fetch;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_req = 1'b0;
  logic [8:0]  line_num = '0;
  logic [20:0] frame_base = '0;
  logic        busy, done, short_p, overrun, buf_sel;
  logic [7:0]  rd_adr = '0;
  logic [31:0] rd_dat;
  logic [1:0]  cmd;
  logic [20:0] adr;
  logic [7:0]  len;
  logic [31:0] dat = '0;
  logic        valid = 1'b0;

  int checks = 0;
  int errors = 0;
  logic        exp_sel = 1'b0;
  logic        exp_ovr = 1'b0;
  logic [31:0] front_start = '0;
  bit          front_known = 1'b0;

  always #5 clk = ~clk;

  fb_line_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .line_req_i   (line_req),
    .line_num_i   (line_num),
    .frame_base_i (frame_base),
    .busy_o       (busy),
    .done_o       (done),
    .short_o      (short_p),
    .overrun_o    (overrun),
    .buf_sel_o    (buf_sel),
    .rd_adr_i     (rd_adr),
    .rd_dat_o     (rd_dat),
    .cmd_o        (cmd),
    .adr_o        (adr),
    .len_o        (len),
    .dat_i        (dat),
    .valid_i      (valid)
  );

  typedef struct {
    logic [8:0]  line;
    logic [20:0] base;
    int          words;
    logic [31:0] start;
    bit          ovr;
    logic [20:0] exp_adr;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic read_front(input logic [31:0] start);
    for (int a = 0; a < 240; a++) begin
      rd_adr = 8'(a);
      @(negedge clk);
      check($sformatf("rd[%0d]", a), rd_dat,
            start + 32'(a));
    end
  endtask

  task automatic run_fetch(input vec_t v);
    int  done_cnt = 0;
    int  done_at = -1;
    int  cmd_hi = 0;
    int  exp_at;
    int  lim;
    bit  sh = 0;
    bit  exp_short;
    exp_short = (v.words < 240);
    exp_at = D + 2 + ((v.words < 240) ? v.words : 240);
    lim = D + v.words + 12;
    @(negedge clk);
    line_req = 1'b1;
    line_num = v.line;
    frame_base = v.base;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("cmd_rise", 32'(cmd), 32'd1);
        check("busy_rise", 32'(busy), 32'd1);
        check("adr", 32'(adr), 32'(v.exp_adr));
        check("len", 32'(len), 32'd240);
      end
      if (i == D + 2)
        check("cmd_drop", 32'(cmd), 32'd0);
      if (i > D + 2 && cmd != 2'd0)
        cmd_hi++;
      if (i == exp_at + 1)
        check("busy_fall", 32'(busy), 32'd0);
      if (done) begin
        done_cnt++;
        done_at = i;
        sh = short_p;
      end
      line_req = (v.ovr && i == D + 60);
      valid = (i >= 1 + D) && (i < 1 + D + v.words);
      dat = v.start + 32'(i - 1 - D);
    end
    valid = 1'b0;
    if (!exp_short) exp_sel = ~exp_sel;
    if (v.ovr) exp_ovr = 1'b1;
    check("done_cnt", 32'(done_cnt), 32'd1);
    check("done_at", 32'(done_at), 32'(exp_at));
    check("short", 32'(sh), 32'(exp_short));
    check("no_recmd", 32'(cmd_hi), 32'd0);
    check("buf_sel", 32'(buf_sel), 32'(exp_sel));
    check("overrun", 32'(overrun), 32'(exp_ovr));
    if (!exp_short) begin
      front_start = v.start;
      front_known = 1'b1;
    end
    if (front_known) read_front(front_start);
    if (v.words > 240) begin
      rd_adr = 8'd240;
      @(negedge clk);
      checks++;
      if (rd_dat === v.start + 32'd240) begin
        errors++;
        $display("FAIL word240: got %0h must differ from %0h",
                 rd_dat, v.start + 32'd240);
      end
    end
  endtask

  initial begin
    vec_t v;
    int dn;
    tbl[0] = '{9'd3,   21'h000000, 240, 32'h0,        1'b0, 21'h000300};
    tbl[1] = '{9'd2,   21'h1FFF00, 240, 32'h1000,     1'b0, 21'h000100};
    tbl[2] = '{9'd5,   21'h010000, 100, 32'h2000,     1'b0, 21'h010500};
    tbl[3] = '{9'd7,   21'h000000, 240, 32'h3000,     1'b1, 21'h000700};
    tbl[4] = '{9'd479, 21'h040000, 245, 32'hA5000000, 1'b0, 21'h05DF00};

    @(negedge clk);
    @(negedge clk);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_len", 32'(len), 32'd240);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_short", 32'(short_p), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_sel", 32'(buf_sel), 32'd0);
    check("rst_rd", rd_dat, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++)
      run_fetch(tbl[k]);

    v = '{9'd1, 21'h0, 240, 32'h5000, 1'b0, 21'h000100};
    run_fetch(v);
    check("pre_abort_sel", 32'(buf_sel), 32'd1);

    @(negedge clk);
    line_req = 1'b1;
    line_num = 9'd4;
    frame_base = '0;
    for (int i = 1; i <= 1 + D + 120; i++) begin
      @(negedge clk);
      line_req = 1'b0;
      valid = (i >= 1 + D);
      dat = 32'h7000 + 32'(i - 1 - D);
    end
    #2 rst = 1'b1;
    #1;
    check("abort_cmd", 32'(cmd), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sel", 32'(buf_sel), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_nodone", 32'(dn), 32'd0);
    exp_sel = 1'b0;
    exp_ovr = 1'b0;
    front_known = 1'b0;

    v = '{9'd9, 21'h100000, 240, 32'h6000, 1'b0, 21'h100900};
    run_fetch(v);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end
endmodule
